// File: rtl/data_cache_wb.sv
// Direct-mapped write-back / write-allocate data cache: hit path, victim writeback,
// word-by-word line refill and a whole-cache clean-and-invalidate flush sequencer.
module data_cache_wb #(
  parameter int AddressSize = 32,
  parameter int WordSize    = 32,
  parameter int NumSets     = 256,
  parameter int LineWords   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [AddressSize-1:0] addr_i,
  input  logic [WordSize-1:0]    wdata_i,
  input  logic [WordSize/8-1:0]  be_i,
  output logic [WordSize-1:0]    rdata_o,
  output logic                   ready_o,
  input  logic                   flush_i,
  output logic                   flush_done_o,
  output logic                   busy_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [AddressSize-1:0] mem_addr_o,
  output logic [WordSize-1:0]    mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [WordSize-1:0]    mem_rdata_i
);
  localparam int BeW      = WordSize / 8;
  localparam int ByteOffW = $clog2(BeW);
  localparam int WordOffW = $clog2(LineWords);
  localparam int OffW     = WordOffW + ByteOffW;
  localparam int IdxW     = $clog2(NumSets);
  localparam int TagW     = AddressSize - IdxW - OffW;
  localparam logic [WordOffW-1:0] LastWord = WordOffW'(LineWords - 1);
  localparam logic [IdxW-1:0]     LastSet  = IdxW'(NumSets - 1);

  typedef enum logic [2:0] {IDLE, WB, RF_REQ, RF_WAIT, RESP, FL_CHK, FL_WB, FL_DONE} state_t;

  state_t              state_reg, state_next;
  logic [WordOffW-1:0] k_reg, k_next;
  logic [IdxW-1:0]     s_reg, s_next;
  logic [NumSets-1:0]  valid_reg, dirty_reg;

  logic [WordSize-1:0] data_mem [NumSets*LineWords];
  logic [TagW-1:0]     tag_mem  [NumSets];

  logic [TagW-1:0]     req_tag;
  logic [IdxW-1:0]     req_idx;
  logic [WordOffW-1:0] req_word;
  logic                unused_addr_bits;
  logic                hit;
  logic [WordSize-1:0] hit_word, merged;
  logic [IdxW-1:0]     wb_idx;
  logic [TagW-1:0]     wb_tag;
  logic [WordSize-1:0] wb_word;
  logic                store_en, refill_en, tag_we, clr_line;

  assign req_tag          = addr_i[AddressSize-1 -: TagW];
  assign req_idx          = addr_i[OffW+IdxW-1:OffW];
  assign req_word         = addr_i[OffW-1:ByteOffW];
  assign unused_addr_bits = ^addr_i[ByteOffW-1:0];

  assign hit      = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_word = data_mem[{req_idx, req_word}];

  for (genvar gi = 0; gi < BeW; gi++) begin : g_merge
    assign merged[gi*8 +: 8] = be_i[gi] ? wdata_i[gi*8 +: 8] : hit_word[gi*8 +: 8];
  end

  // The flush walks sets with s_reg; a miss writes back the line at the request index.
  assign wb_idx  = (state_reg == FL_WB) ? s_reg : req_idx;
  assign wb_tag  = tag_mem[wb_idx];
  assign wb_word = data_mem[{wb_idx, k_reg}];

  assign busy_o  = (state_reg != IDLE);
  assign rdata_o = ready_o ? hit_word : '0;

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    s_next       = s_reg;
    ready_o      = 1'b0;
    flush_done_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    store_en     = 1'b0;
    refill_en    = 1'b0;
    tag_we       = 1'b0;
    clr_line     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_i) begin
          if (hit) begin
            ready_o  = 1'b1;
            store_en = we_i;
          end else begin
            k_next     = '0;
            state_next = (valid_reg[req_idx] && dirty_reg[req_idx]) ? WB : RF_REQ;
          end
        end else if (flush_i) begin
          s_next     = '0;
          state_next = FL_CHK;
        end
      end
      WB, FL_WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {wb_tag, wb_idx, k_reg, {ByteOffW{1'b0}}};
        mem_wdata_o = wb_word;
        if (mem_gnt_i) begin
          k_next = k_reg + 1'b1;
          if (k_reg == LastWord) begin
            if (state_reg == WB) begin
              state_next = RF_REQ;
            end else begin
              clr_line   = 1'b1;
              s_next     = s_reg + 1'b1;
              state_next = (s_reg == LastSet) ? FL_DONE : FL_CHK;
            end
          end
        end
      end
      RF_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, req_idx, k_reg, {ByteOffW{1'b0}}};
        if (mem_gnt_i) state_next = RF_WAIT;
      end
      RF_WAIT: begin
        if (mem_rvalid_i) begin
          refill_en = 1'b1;
          k_next    = k_reg + 1'b1;
          if (k_reg == LastWord) begin
            tag_we     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = RF_REQ;
          end
        end
      end
      RESP: begin
        ready_o    = 1'b1;
        store_en   = we_i;
        state_next = IDLE;
      end
      FL_CHK: begin
        if (valid_reg[s_reg] && dirty_reg[s_reg]) begin
          k_next     = '0;
          state_next = FL_WB;
        end else begin
          clr_line   = 1'b1;
          s_next     = s_reg + 1'b1;
          state_next = (s_reg == LastSet) ? FL_DONE : FL_CHK;
        end
      end
      FL_DONE: begin
        flush_done_o = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      s_reg     <= '0;
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      s_reg     <= s_next;
      if (tag_we) begin
        valid_reg[req_idx] <= 1'b1;
        dirty_reg[req_idx] <= 1'b0;
      end
      if (store_en) dirty_reg[req_idx] <= 1'b1;
      if (clr_line) begin
        valid_reg[s_reg] <= 1'b0;
        dirty_reg[s_reg] <= 1'b0;
      end
    end
  end

  // Data and tag storage carry no reset; validity is tracked by valid_reg alone.
  always_ff @(posedge clk) begin
    if (refill_en)
      data_mem[{req_idx, k_reg}] <= mem_rdata_i;
    else if (store_en)
      data_mem[{req_idx, req_word}] <= merged;
    if (tag_we) tag_mem[req_idx] <= req_tag;
  end
endmodule
